// File: rtl/edit_field_bank.sv
// ---------------------------------------------------------------------------
// edit_field_bank
//
// Holds NUM_GROUPS groups of NUM_FIELDS editable fields, for example the
// sec/min/hour fields of a clock, a date and a timer. While idle the bank can
// snapshot live values. While the user is editing, up/down buttons step the
// field under the cursor within per-field limits, and left/right buttons move
// the cursor. When editing ends, a one-cycle commit strobe is issued.
//
// Optional feature: define EDIT_AUTOREPEAT_EN to enable auto-repeat. A held
// up or down button then produces an extra step after REPEAT_DELAY cycles,
// and another step every REPEAT_PERIOD cycles after that. Without the macro,
// only button edges produce steps and both repeat parameters are unused.
//
// Ports
//   clk                      system clock
//   reset                    asynchronous active-low reset
//   edit_en                  level; high while the user is editing
//   grp_sel                  group to edit (sampled on the edit_en rise)
//   load                     snapshot strobe, honoured only in IDLE
//   load_data                live values; field f of group g is at g*NUM_FIELDS+f
//   fld_min / fld_max        per-field limits for the active group
//   btn_up/dn/left/right     debounced button levels
//   edit_data                registered fields of the displayed group
//   cursor                   selected field index
//   edit_state               0=IDLE, 1=EDIT, 2=COMMIT
//   commit_stb               one-cycle pulse when editing ends
//   commit_grp               group that was committed
// ---------------------------------------------------------------------------
module edit_field_bank #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_FIELDS    = 3,
    parameter int NUM_GROUPS    = 3,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   edit_en,
    input  logic [((NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1)-1:0] grp_sel,
    input  logic                                                   load,
    input  logic [NUM_GROUPS*NUM_FIELDS*DATA_WIDTH-1:0]            load_data,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0]                       fld_min,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0]                       fld_max,
    input  logic                                                   btn_up,
    input  logic                                                   btn_dn,
    input  logic                                                   btn_left,
    input  logic                                                   btn_right,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0]                       edit_data,
    output logic [((NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1)-1:0] cursor,
    output logic [1:0]                                             edit_state,
    output logic                                                   commit_stb,
    output logic [((NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1)-1:0] commit_grp
);

    localparam int GW    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int CW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int GRP_W = NUM_FIELDS * DATA_WIDTH;
    localparam int TOTAL = NUM_GROUPS * NUM_FIELDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                        state;
    logic [TOTAL*DATA_WIDTH-1:0]   fld_q;
    logic [GW-1:0]                 act_grp;
    logic                          edit_en_q;
    logic [3:0]                    btn_q;     // {right, left, dn, up}

    logic [GW-1:0]                 grp_eff;
    logic [GW-1:0]                 disp_grp;
    logic [GRP_W-1:0]              disp_data;
    int                            cur_base;
    logic [DATA_WIDTH-1:0]         cur_val;
    logic [DATA_WIDTH-1:0]         cur_min;
    logic [DATA_WIDTH-1:0]         cur_max;
    logic [DATA_WIDTH-1:0]         next_val;
    logic                          val_upd;
    logic [CW-1:0]                 next_cursor;
    logic                          edit_rise;
    logic                          edit_fall;
    logic                          up_edge;
    logic                          dn_edge;
    logic                          left_edge;
    logic                          right_edge;
    logic                          up_step;
    logic                          dn_step;
    logic                          rpt_up;
    logic                          rpt_dn;

    always_comb begin
        edit_rise  = edit_en & ~edit_en_q;
        edit_fall  = ~edit_en & edit_en_q;
        up_edge    = btn_up    & ~btn_q[0];
        dn_edge    = btn_dn    & ~btn_q[1];
        left_edge  = btn_left  & ~btn_q[2];
        right_edge = btn_right & ~btn_q[3];
        up_step    = up_edge | rpt_up;
        dn_step    = dn_edge | rpt_dn;
    end

    // Out-of-range group selections fall back to group 0.
    always_comb begin
        grp_eff   = (int'(grp_sel) < NUM_GROUPS) ? grp_sel : '0;
        disp_grp  = (state == IDLE) ? grp_eff : act_grp;
        disp_data = fld_q[int'(disp_grp)*GRP_W +: GRP_W];
    end

    // Value step for the field under the (pre-move) cursor.
    always_comb begin
        cur_base = (int'(act_grp) * NUM_FIELDS + int'(cursor)) * DATA_WIDTH;
        cur_val  = fld_q[cur_base +: DATA_WIDTH];
        cur_min  = fld_min[int'(cursor)*DATA_WIDTH +: DATA_WIDTH];
        cur_max  = fld_max[int'(cursor)*DATA_WIDTH +: DATA_WIDTH];
        val_upd  = 1'b0;
        next_val = cur_val;
        if (up_step ^ dn_step) begin
            val_upd = 1'b1;
            if (cur_val < cur_min || cur_val > cur_max)
                next_val = cur_min;
            else if (up_step)
                next_val = (cur_val >= cur_max) ? cur_min : cur_val + DATA_WIDTH'(1);
            else
                next_val = (cur_val <= cur_min) ? cur_max : cur_val - DATA_WIDTH'(1);
        end
    end

    // "Right" moves toward field 0; "left" moves toward the most significant field.
    always_comb begin
        next_cursor = cursor;
        if (right_edge && !left_edge)
            next_cursor = (cursor == '0) ? CW'(NUM_FIELDS - 1) : cursor - CW'(1);
        else if (left_edge && !right_edge)
            next_cursor = (int'(cursor) == NUM_FIELDS - 1) ? '0 : cursor + CW'(1);
    end

`ifdef EDIT_AUTOREPEAT_EN
    // rpt_cnt counts held cycles since the last step. The first threshold is
    // REPEAT_DELAY; once a repeat step fires, the threshold becomes
    // REPEAT_PERIOD (rpt_armed).
    logic [31:0] rpt_cnt;
    logic        rpt_armed;
    logic        rpt_hold;
    logic        rpt_fire;

    always_comb begin
        rpt_hold = (state == EDIT) && (btn_up ^ btn_dn);
        rpt_fire = rpt_hold && !(up_edge || dn_edge) &&
                   (rpt_cnt == (rpt_armed ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY)));
        rpt_up   = rpt_fire & btn_up;
        rpt_dn   = rpt_fire & btn_dn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!rpt_hold) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (up_edge || dn_edge) begin
            rpt_cnt   <= 32'd1;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= 32'd1;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 32'd1;
        end
    end
`else
    always_comb begin
        rpt_up = 1'b0;
        rpt_dn = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fld_q      <= '0;
            act_grp    <= '0;
            cursor     <= '0;
            edit_data  <= '0;
            commit_stb <= 1'b0;
            commit_grp <= '0;
            edit_en_q  <= 1'b0;
            btn_q      <= '0;
        end else begin
            edit_en_q  <= edit_en;
            btn_q      <= {btn_right, btn_left, btn_dn, btn_up};
            edit_data  <= disp_data;
            commit_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (load)
                        fld_q <= load_data;
                    if (edit_rise) begin
                        state   <= EDIT;
                        act_grp <= grp_eff;
                        cursor  <= CW'(NUM_FIELDS - 1);
                    end
                end
                EDIT: begin
                    if (val_upd)
                        fld_q[cur_base +: DATA_WIDTH] <= next_val;
                    cursor <= next_cursor;
                    if (edit_fall) begin
                        state      <= COMMIT;
                        commit_stb <= 1'b1;
                        commit_grp <= act_grp;
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb edit_state = state;

endmodule

// File: doc/edit_field_bank.md
EDIT_FIELD_BANK -- requirements
Module: edit_field_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bit width of one editable field.
REQ-002 Parameter NUM_FIELDS, default 3: fields per group (e.g. sec/min/hour).
REQ-003 Parameter NUM_GROUPS, default 3: groups held (hour, date, timer).
REQ-004 Parameter REPEAT_DELAY, default 50000000: held-button cycles before the first auto-repeat step.
REQ-005 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat steps.
REQ-006 The block SHALL have one clock, clk, and an asynchronous active-low reset, reset.
REQ-007 Ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  async active-low reset
- edit_en  in  1  level; high = user editing
- grp_sel  in  GW=max(1,clog2(NUM_GROUPS))  group to edit
- load  in  1  snapshot strobe
- load_data  in  NUM_GROUPS*NUM_FIELDS*DATA_WIDTH  live values; field f of group g at index g*NUM_FIELDS+f
- fld_min  in  NUM_FIELDS*DATA_WIDTH  per-field lower limit, active group
- fld_max  in  NUM_FIELDS*DATA_WIDTH  per-field upper limit, active group
- btn_up, btn_dn, btn_left, btn_right  in  1 each  debounced levels
- edit_data  out  NUM_FIELDS*DATA_WIDTH  registered fields of the active group
- cursor  out  clog2(NUM_FIELDS)  selected field index
- edit_state  out  2  0=IDLE, 1=EDIT, 2=COMMIT
- commit_stb  out  1  one-cycle pulse on edit exit
- commit_grp  out  GW  group committed

Function
REQ-008 The FSM SHALL have states IDLE, EDIT and COMMIT.
REQ-009 In IDLE with load=1, all NUM_GROUPS*NUM_FIELDS registers SHALL capture load_data on the next edge.
REQ-010 In IDLE, a rising edge of edit_en SHALL cause the following on the next cycle:
- enter EDIT
- latch grp_sel as the active group
- set cursor=NUM_FIELDS-1
REQ-011 grp_sel changes and load SHALL be ignored while in EDIT or COMMIT.
REQ-012 Button steps SHALL be generated on the rising edge of each button, using registered previous levels; a held level SHALL produce exactly one step.
REQ-013 On an up step, the field at cursor SHALL wrap to fld_min when value >= fld_max; otherwise it SHALL increment by 1.
REQ-014 On a down step, the field at cursor SHALL wrap to fld_max when value <= fld_min; otherwise it SHALL decrement by 1.
REQ-015 An up or down step on a field whose value is outside [fld_min,fld_max] SHALL load fld_min.
REQ-016 Simultaneous up and down steps SHALL leave the field unchanged.
REQ-017 Cursor movement SHALL wrap:
- right: cursor-1, wrapping 0 -> NUM_FIELDS-1
- left: cursor+1, wrapping NUM_FIELDS-1 -> 0
- simultaneous left and right: no move
REQ-018 A value step and a cursor step in the same cycle SHALL both apply, the value using the pre-move cursor.
REQ-019 Falling edge of edit_en in EDIT SHALL go to COMMIT for exactly one cycle with commit_stb=1 and commit_grp = active group, then return to IDLE.
REQ-020 edit_data SHALL reflect the active group's registers one cycle after any change; in IDLE it SHALL show the group selected by grp_sel.
REQ-021 Arithmetic SHALL be unsigned DATA_WIDTH with no overflow beyond the limits.

Reset
REQ-022 Reset assertion SHALL asynchronously force:
- all field registers = 0
- cursor = 0
- edit_state = IDLE
- commit_stb = 0, commit_grp = 0
- edit_data = 0
- button history = 0
- repeat counters = 0
REQ-023 Reset asserted mid-EDIT SHALL abandon the edit without a commit_stb pulse.

Configuration
REQ-024 With macro EDIT_AUTOREPEAT_EN defined, up/dn held alone in EDIT SHALL generate an extra step after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles until release; the counter SHALL clear on release or on leaving EDIT.
REQ-025 Without EDIT_AUTOREPEAT_EN, only edge steps SHALL occur, and REPEAT_DELAY and REPEAT_PERIOD SHALL be unused.

Verification
REQ-026 Scenario 1: load group 0 = {sec 58, min 10, hr 23}, limits 0..59/0..59/0..23, edit_en rise, btn_up pulse -> hr wraps to 0, cursor=2.
REQ-027 Scenario 2: cursor=2, btn_right x3 -> cursor 1, 0, 2; then btn_left -> cursor 0.
REQ-028 Scenario 3: sec=0, limits 0..59, btn_dn -> 59; btn_up and btn_dn together -> 59 unchanged.
REQ-029 Scenario 4: hr=0 with limits 1..12 (12-hour format), btn_up -> 1; edit_en fall -> commit_stb high for 1 cycle, commit_grp=0, edit_state back to 0.
REQ-030 Scenario 5: reset low mid-EDIT -> all outputs 0 immediately, no commit_stb; load during EDIT has no effect.
REQ-031 Scenario 6 (EDIT_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2): hold btn_up 10 cycles from min=5 -> min=9 (edge step plus 3 repeats).
